// File: rtl/ysyx_25030085_lsu_pkg.sv
// Shared constants for the load/store unit: MemOp encoding, FSM state codes
// and the access-size helper.
package ysyx_25030085_lsu_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_D  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  localparam logic [2:0] OP_WU = 3'b110;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  // Access size in bytes; 0 marks an encoding with no defined size.
  function automatic logic [3:0] access_size(input logic [2:0] op);
    logic [3:0] size;
    case (op)
      OP_B, OP_BU: size = 4'd1;
      OP_H, OP_HU: size = 4'd2;
      OP_W, OP_WU: size = 4'd4;
      OP_D:        size = 4'd8;
      default:     size = 4'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/ysyx_25030085_lsu_align.sv
// Combinational lane logic: byte mask and store-data shift, load extraction
// with sign/zero extension, and the misaligned/illegal-op check.
module ysyx_25030085_lsu_align #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 32
) (
  input  logic [2:0]        op,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [AW-1:0]     aligned_addr,
  output logic [XLEN/8-1:0] wmask,
  output logic [XLEN-1:0]   wdata_sh,
  output logic [XLEN-1:0]   load_data,
  output logic              err
);
  import ysyx_25030085_lsu_pkg::*;

  localparam int unsigned MW = XLEN / 8;
  localparam int unsigned OW = $clog2(MW);

  logic [OW-1:0]   off;
  logic [3:0]      size;
  logic [OW-1:0]   size_m1;
  logic [MW-1:0]   base_mask;
  logic [XLEN-1:0] rsh;
  logic            illegal;
  logic            misaligned;

  assign off          = addr[OW-1:0];
  assign size         = access_size(op);
  assign size_m1      = OW'(size - 4'd1);
  assign aligned_addr = addr & ~(AW'(MW - 1));

  // Unsized base mask before shifting into the addressed lane.
  always_comb begin
    base_mask = '0;
    case (size)
      4'd1:    base_mask = MW'(8'h01);
      4'd2:    base_mask = MW'(8'h03);
      4'd4:    base_mask = MW'(8'h0F);
      4'd8:    base_mask = MW'(8'hFF);
      default: base_mask = '0;
    endcase
  end

  assign wmask    = base_mask << off;
  assign wdata_sh = wdata << {off, 3'b000};
  assign rsh      = rdata >> {off, 3'b000};

  // Unsigned variants only make sense for loads; d/wu need a 64-bit datapath.
  assign illegal    = (op == 3'b111) ||
                      ((XLEN == 32) && ((op == OP_D) || (op == OP_WU))) ||
                      (we && op[2]);
  assign misaligned = |(off & size_m1);
  assign err        = illegal || misaligned;

  // Extract the addressed lane and extend it to the full data width.
  always_comb begin
    load_data = '0;
    case (op)
      OP_B:    load_data = XLEN'($signed(rsh[7:0]));
      OP_H:    load_data = XLEN'($signed(rsh[15:0]));
      OP_W:    load_data = XLEN'($signed(rsh[31:0]));
      OP_D:    load_data = rsh;
      OP_BU:   load_data = XLEN'(rsh[7:0]);
      OP_HU:   load_data = XLEN'(rsh[15:0]);
      OP_WU:   load_data = XLEN'(rsh[31:0]);
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_25030085_lsu.sv
// Load/store unit: accepts one request, issues a registered aligned bus
// request, waits for a variable-latency response and returns the result.
module ysyx_25030085_lsu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [AW-1:0]     req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_err
);
  import ysyx_25030085_lsu_pkg::*;

  localparam int unsigned MW = XLEN / 8;

  state_t          state_q, state_d;
  logic            we_q;
  logic [2:0]      op_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   mem_addr_q;
  logic            mem_we_q;
  logic [MW-1:0]   mem_wmask_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [XLEN-1:0] resp_data_q;
  logic            resp_err_q;

  logic [2:0]      al_op;
  logic [AW-1:0]   al_addr;
  logic            al_we;
  logic [AW-1:0]   al_aligned_addr;
  logic [MW-1:0]   al_wmask;
  logic [XLEN-1:0] al_wdata_sh;
  logic [XLEN-1:0] al_load_data;
  logic            al_err;

  // In IDLE the checker looks at the incoming request; afterwards it looks at
  // the latched one so load extraction uses the original offset and op.
  assign al_op   = (state_q == ST_IDLE) ? req_op   : op_q;
  assign al_addr = (state_q == ST_IDLE) ? req_addr : addr_q;
  assign al_we   = (state_q == ST_IDLE) ? req_we   : we_q;

  ysyx_25030085_lsu_align #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_align (
    .op           (al_op),
    .we           (al_we),
    .addr         (al_addr),
    .wdata        (req_wdata),
    .rdata        (mem_rdata),
    .aligned_addr (al_aligned_addr),
    .wmask        (al_wmask),
    .wdata_sh     (al_wdata_sh),
    .load_data    (al_load_data),
    .err          (al_err)
  );

  // Next-state logic for the single-outstanding transaction FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = al_err ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
      ST_WAIT: if (mem_rsp_valid) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latches and registered bus/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      op_q        <= 3'b000;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q   <= req_we;
            op_q   <= req_op;
            addr_q <= req_addr;
            if (al_err) begin
              resp_err_q  <= 1'b1;
              resp_data_q <= '0;
            end else begin
              mem_addr_q  <= al_aligned_addr;
              mem_we_q    <= req_we;
              mem_wmask_q <= al_wmask;
              mem_wdata_q <= al_wdata_sh;
            end
          end
        end
        ST_REQ: begin
          // Bus fields are held until the handshake, then parked at zero.
          if (mem_req_ready) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= '0;
            mem_wdata_q <= '0;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            resp_data_q <= we_q ? '0 : al_load_data;
            resp_err_q  <= 1'b0;
          end
        end
        ST_RESP: begin
          resp_data_q <= '0;
          resp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = rst_n && (state_q == ST_IDLE);
  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wmask     = mem_wmask_q;
  assign mem_wdata     = mem_wdata_q;
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_data     = resp_data_q;
  assign resp_err      = resp_err_q;

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Directed bench for the LSU: one XLEN=32 and one XLEN=64 instance.
module tb_ysyx_25030085_lsu;

  logic clk;
  logic rst_n;

  // XLEN=32 instance signals
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [2:0]  a_req_op;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_mem_req_valid, a_mem_req_ready, a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wmask;
  logic        a_mem_rsp_valid;
  logic [31:0] a_mem_rdata;
  logic        a_resp_valid, a_resp_err;
  logic [31:0] a_resp_data;

  // XLEN=64 instance signals
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [2:0]  b_req_op;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic        b_mem_req_valid, b_mem_req_ready, b_mem_we;
  logic [31:0] b_mem_addr;
  logic [63:0] b_mem_wdata;
  logic [7:0]  b_mem_wmask;
  logic        b_mem_rsp_valid;
  logic [63:0] b_mem_rdata;
  logic        b_resp_valid, b_resp_err;
  logic [63:0] b_resp_data;

  int checks   = 0;
  int failures = 0;
  int rc32     = 0;
  int rc_base;

  ysyx_25030085_lsu #(.XLEN(32), .AW(32)) dut32 (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (a_req_valid),
    .req_ready     (a_req_ready),
    .req_we        (a_req_we),
    .req_op        (a_req_op),
    .req_addr      (a_req_addr),
    .req_wdata     (a_req_wdata),
    .mem_req_valid (a_mem_req_valid),
    .mem_req_ready (a_mem_req_ready),
    .mem_addr      (a_mem_addr),
    .mem_we        (a_mem_we),
    .mem_wmask     (a_mem_wmask),
    .mem_wdata     (a_mem_wdata),
    .mem_rsp_valid (a_mem_rsp_valid),
    .mem_rdata     (a_mem_rdata),
    .resp_valid    (a_resp_valid),
    .resp_data     (a_resp_data),
    .resp_err      (a_resp_err)
  );

  ysyx_25030085_lsu #(.XLEN(64), .AW(32)) dut64 (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (b_req_valid),
    .req_ready     (b_req_ready),
    .req_we        (b_req_we),
    .req_op        (b_req_op),
    .req_addr      (b_req_addr),
    .req_wdata     (b_req_wdata),
    .mem_req_valid (b_mem_req_valid),
    .mem_req_ready (b_mem_req_ready),
    .mem_addr      (b_mem_addr),
    .mem_we        (b_mem_we),
    .mem_wmask     (b_mem_wmask),
    .mem_wdata     (b_mem_wdata),
    .mem_rsp_valid (b_mem_rsp_valid),
    .mem_rdata     (b_mem_rdata),
    .resp_valid    (b_resp_valid),
    .resp_data     (b_resp_data),
    .resp_err      (b_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completion pulses of the 32-bit instance.
  always @(posedge clk) if (a_resp_valid) rc32 <= rc32 + 1;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request on a negedge; returns on the following negedge.
  task automatic issue32(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd);
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_op    = op;
    a_req_addr  = addr;
    a_req_wdata = wd;
    chk("req_ready_idle", 64'(a_req_ready), 64'd1);
    @(negedge clk);
    a_req_valid = 1'b0;
  endtask

  // Minimum-latency transaction on the 32-bit instance.
  task automatic fast32(input string tag, input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input logic [31:0] e_addr,
                        input logic [3:0] e_mask, input logic [31:0] e_wdata,
                        input logic [31:0] e_data);
    issue32(we, op, addr, wd);
    chk({tag, "_mreq_valid"}, 64'(a_mem_req_valid), 64'd1);
    chk({tag, "_maddr"}, 64'(a_mem_addr), 64'(e_addr));
    chk({tag, "_mwmask"}, 64'(a_mem_wmask), 64'(e_mask));
    chk({tag, "_mwe"}, 64'(a_mem_we), 64'(we));
    if (we) chk({tag, "_mwdata"}, 64'(a_mem_wdata), 64'(e_wdata));
    chk({tag, "_ready_busy"}, 64'(a_req_ready), 64'd0);
    @(negedge clk);
    chk({tag, "_mreq_drop"}, 64'(a_mem_req_valid), 64'd0);
    chk({tag, "_no_early_resp"}, 64'(a_resp_valid), 64'd0);
    a_mem_rsp_valid = 1'b1;
    a_mem_rdata     = rdata;
    @(negedge clk);
    a_mem_rsp_valid = 1'b0;
    chk({tag, "_resp_valid"}, 64'(a_resp_valid), 64'd1);
    chk({tag, "_resp_data"}, 64'(a_resp_data), 64'(e_data));
    chk({tag, "_resp_err"}, 64'(a_resp_err), 64'd0);
    @(negedge clk);
    chk({tag, "_resp_pulse"}, 64'(a_resp_valid), 64'd0);
  endtask

  // Rejected request: error response one cycle after accept, no bus traffic.
  task automatic err32(input string tag, input logic we, input logic [2:0] op,
                       input logic [31:0] addr);
    issue32(we, op, addr, 32'h0);
    chk({tag, "_resp_valid"}, 64'(a_resp_valid), 64'd1);
    chk({tag, "_resp_err"}, 64'(a_resp_err), 64'd1);
    chk({tag, "_resp_data"}, 64'(a_resp_data), 64'd0);
    chk({tag, "_no_mreq"}, 64'(a_mem_req_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_resp_pulse"}, 64'(a_resp_valid), 64'd0);
    chk({tag, "_no_mreq2"}, 64'(a_mem_req_valid), 64'd0);
  endtask

  task automatic fast64(input string tag, input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [63:0] wd,
                        input logic [63:0] rdata, input logic [31:0] e_addr,
                        input logic [7:0] e_mask, input logic [63:0] e_wdata,
                        input logic [63:0] e_data);
    b_req_valid = 1'b1;
    b_req_we    = we;
    b_req_op    = op;
    b_req_addr  = addr;
    b_req_wdata = wd;
    @(negedge clk);
    b_req_valid = 1'b0;
    chk({tag, "_mreq_valid"}, 64'(b_mem_req_valid), 64'd1);
    chk({tag, "_maddr"}, 64'(b_mem_addr), 64'(e_addr));
    chk({tag, "_mwmask"}, 64'(b_mem_wmask), 64'(e_mask));
    if (we) chk({tag, "_mwdata"}, b_mem_wdata, e_wdata);
    @(negedge clk);
    b_mem_rsp_valid = 1'b1;
    b_mem_rdata     = rdata;
    @(negedge clk);
    b_mem_rsp_valid = 1'b0;
    chk({tag, "_resp_valid"}, 64'(b_resp_valid), 64'd1);
    chk({tag, "_resp_data"}, b_resp_data, e_data);
    chk({tag, "_resp_err"}, 64'(b_resp_err), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_op = 3'b000;
    a_req_addr = '0; a_req_wdata = '0;
    a_mem_req_ready = 1'b1; a_mem_rsp_valid = 1'b0; a_mem_rdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_op = 3'b000;
    b_req_addr = '0; b_req_wdata = '0;
    b_mem_req_ready = 1'b1; b_mem_rsp_valid = 1'b0; b_mem_rdata = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(a_req_ready), 64'd0);
    chk("rst_mreq_valid", 64'(a_mem_req_valid), 64'd0);
    chk("rst_resp_valid", 64'(a_resp_valid), 64'd0);
    chk("rst_b_req_ready", 64'(b_req_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 64'(a_req_ready), 64'd1);
    chk("idle_maddr", 64'(a_mem_addr), 64'd0);
    chk("idle_mwmask", 64'(a_mem_wmask), 64'd0);
    chk("idle_mwdata", 64'(a_mem_wdata), 64'd0);
    chk("idle_mwe", 64'(a_mem_we), 64'd0);
    chk("idle_resp_data", 64'(a_resp_data), 64'd0);
    chk("idle_resp_err", 64'(a_resp_err), 64'd0);

    // Stores and loads at minimum latency
    fast32("sb", 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h1234_5678,
           32'h8000_0000, 4'b1000, 32'hA500_0000, 32'h0);
    fast32("sh", 1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0,
           32'h8000_0000, 4'b1100, 32'hBEEF_0000, 32'h0);
    fast32("sw", 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,
           32'h8000_0004, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    fast32("lb", 1'b0, 3'b000, 32'h8000_0002, 32'h0, 32'h12F4_5678,
           32'h8000_0000, 4'b0100, 32'h0, 32'hFFFF_FFF4);
    fast32("lbu", 1'b0, 3'b100, 32'h8000_0002, 32'h0, 32'h12F4_5678,
           32'h8000_0000, 4'b0100, 32'h0, 32'h0000_00F4);
    fast32("lh", 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_0000,
           32'h8000_0000, 4'b1100, 32'h0, 32'hFFFF_8001);
    fast32("lhu", 1'b0, 3'b101, 32'h8000_0000, 32'h0, 32'h1234_F00D,
           32'h8000_0000, 4'b0011, 32'h0, 32'h0000_F00D);
    fast32("lw", 1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'h89AB_CDEF,
           32'h8000_0008, 4'b1111, 32'h0, 32'h89AB_CDEF);

    // Misaligned and illegal requests
    err32("lh_mis", 1'b0, 3'b001, 32'h8000_0001);
    err32("sw_mis", 1'b1, 3'b010, 32'h8000_0002);
    err32("lwu32", 1'b0, 3'b110, 32'h8000_0004);
    err32("ld32", 1'b0, 3'b011, 32'h8000_0000);
    err32("sbu", 1'b1, 3'b100, 32'h8000_0000);
    err32("op7", 1'b0, 3'b111, 32'h8000_0000);

    // Backpressure: request held 5 cycles, stray response ignored in REQ
    rc_base = rc32;
    a_mem_req_ready = 1'b0;
    issue32(1'b0, 3'b010, 32'h8000_0010, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_mreq_valid", 64'(a_mem_req_valid), 64'd1);
      chk("bp_maddr", 64'(a_mem_addr), 64'h8000_0010);
      chk("bp_mwmask", 64'(a_mem_wmask), 64'hF);
      chk("bp_ready", 64'(a_req_ready), 64'd0);
      a_mem_rsp_valid = (i == 2);
      a_mem_rdata     = 32'h5555_5555;
      @(negedge clk);
    end
    a_mem_rsp_valid = 1'b0;
    chk("bp_still_req", 64'(a_mem_req_valid), 64'd1);
    chk("bp_no_resp", 64'(a_resp_valid), 64'd0);
    a_mem_req_ready = 1'b1;
    @(negedge clk);
    chk("bp_mreq_drop", 64'(a_mem_req_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_wait_resp", 64'(a_resp_valid), 64'd0);
      chk("bp_wait_ready", 64'(a_req_ready), 64'd0);
      @(negedge clk);
    end
    a_mem_rsp_valid = 1'b1;
    a_mem_rdata     = 32'hCAFE_F00D;
    @(negedge clk);
    a_mem_rsp_valid = 1'b0;
    chk("bp_resp_valid", 64'(a_resp_valid), 64'd1);
    chk("bp_resp_data", 64'(a_resp_data), 64'hCAFE_F00D);
    @(negedge clk);
    chk("bp_resp_count", 64'(rc32 - rc_base), 64'd1);
    chk("bp_ready_back", 64'(a_req_ready), 64'd1);

    // Reset while waiting, then a late response
    rc_base = rc32;
    issue32(1'b0, 3'b000, 32'h8000_0002, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_req_ready", 64'(a_req_ready), 64'd0);
    chk("mr_mreq_valid", 64'(a_mem_req_valid), 64'd0);
    chk("mr_maddr", 64'(a_mem_addr), 64'd0);
    chk("mr_resp_valid", 64'(a_resp_valid), 64'd0);
    chk("mr_resp_data", 64'(a_resp_data), 64'd0);
    chk("mr_resp_err", 64'(a_resp_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_mem_rsp_valid = 1'b1;
    a_mem_rdata     = 32'h12F4_5678;
    @(negedge clk);
    a_mem_rsp_valid = 1'b0;
    chk("mr_late_ignored", 64'(a_resp_valid), 64'd0);
    chk("mr_ready", 64'(a_req_ready), 64'd1);
    @(negedge clk);
    chk("mr_resp_count", 64'(rc32 - rc_base), 64'd0);
    fast32("mr_lbu", 1'b0, 3'b100, 32'h8000_0002, 32'h0, 32'h12F4_5678,
           32'h8000_0000, 4'b0100, 32'h0, 32'h0000_00F4);

    // XLEN=64 instance
    chk("b_ready", 64'(b_req_ready), 64'd1);
    fast64("lwu64", 1'b0, 3'b110, 32'h8000_0004, 64'h0, 64'h89AB_CDEF_0000_0000,
           32'h8000_0000, 8'hF0, 64'h0, 64'h0000_0000_89AB_CDEF);
    fast64("lw64", 1'b0, 3'b010, 32'h8000_0004, 64'h0, 64'h89AB_CDEF_0000_0000,
           32'h8000_0000, 8'hF0, 64'h0, 64'hFFFF_FFFF_89AB_CDEF);
    fast64("sd64", 1'b1, 3'b011, 32'h8000_0008, 64'h1122_3344_5566_7788, 64'h0,
           32'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788, 64'h0);
    fast64("sh64", 1'b1, 3'b001, 32'h8000_0006, 64'h0000_0000_0000_BEEF, 64'h0,
           32'h8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
